// File: rtl/jtcontra_sndcmd_pkg.sv
// Shared definitions for the main-CPU sound command transmitter:
// sequencer state encoding and default parameter values.
package jtcontra_sndcmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int DEF_FIFO_AW = 2;
  localparam int DEF_IRQ_W   = 8;
  localparam int DEF_TOUT_W  = 15;
  localparam int DEF_TOUT    = 24000;

endpackage

// File: rtl/jtcontra_sndcmd_fifo.sv
// Small synchronous byte FIFO. Storage has no reset so it maps to RAM;
// the head byte is captured into a register on pop.
module jtcontra_sndcmd_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [7:0]         r_dout;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // When full, a simultaneous push lands on the slot being read; the
  // pop still sees the old head because both use pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_dout;
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);

endmodule

// File: rtl/jtcontra_sndcmd.sv
// Sound command transmitter: queues main CPU writes and hands them one at a
// time to the sound CPU via latch + IRQ pulse, waiting for ack or timeout.
module jtcontra_sndcmd
  import jtcontra_sndcmd_pkg::*;
#(
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int IRQ_W   = DEF_IRQ_W,
  parameter int TOUT_W  = DEF_TOUT_W,
  parameter int TOUT    = DEF_TOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  output logic       cmd_full,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  input  logic       snd_ack,
  output logic       busy,
  output logic       ovf,
  output logic       tout,
  input  logic       flag_clr
);

  localparam int                PCNT_W    = $clog2(IRQ_W + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(IRQ_W - 1);
  localparam logic [TOUT_W-1:0] TCNT_LAST = TOUT_W'(TOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_pop;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [7:0]          w_fifo_dout;
  logic                w_pulse_end;
  logic                w_timeout;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [TOUT_W-1:0]   r_tcnt;
  logic                r_ack_seen;
  logic                r_irq;
  logic [7:0]          r_latch;
  logic                r_ovf;
  logic                r_tout;

  assign w_pop       = (r_state == ST_IDLE) & ~w_fifo_empty;
  assign w_push      = cmd_we & (~w_fifo_full | w_pop);
  assign w_pulse_end = (r_state == ST_PULSE) && (r_pcnt == PCNT_LAST);
  assign w_timeout   = (r_state == ST_WAIT) && !snd_ack && (r_tcnt == TCNT_LAST);

  jtcontra_sndcmd_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (cmd_din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_fifo_empty) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_PULSE;
      ST_PULSE: if (w_pulse_end) w_state_next = (r_ack_seen | snd_ack) ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (snd_ack || (r_tcnt == TCNT_LAST)) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // The IRQ output trails the PULSE state by one cycle, so the latch has a
  // full cycle of setup ahead of the rising edge seen by the sound CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq      <= 1'b0;
      r_latch    <= '0;
      r_pcnt     <= '0;
      r_tcnt     <= '0;
      r_ack_seen <= 1'b0;
    end else begin
      r_irq <= (r_state == ST_PULSE);
      if (r_state == ST_LOAD) r_latch <= w_fifo_dout;
      r_pcnt <= ((r_state == ST_PULSE) && !w_pulse_end) ? r_pcnt + 1'b1 : '0;
      r_tcnt <= ((r_state == ST_WAIT) && (w_state_next == ST_WAIT)) ? r_tcnt + 1'b1 : '0;
      if (w_pulse_end)                            r_ack_seen <= 1'b0;
      else if ((r_state == ST_PULSE) && snd_ack)  r_ack_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_tout <= 1'b0;
    end else if (flag_clr) begin
      r_ovf  <= 1'b0;
      r_tout <= 1'b0;
    end else begin
      if (cmd_we && !w_push) r_ovf  <= 1'b1;
      if (w_timeout)         r_tout <= 1'b1;
    end
  end

  assign cmd_full  = w_fifo_full;
  assign snd_latch = r_latch;
  assign snd_irq   = r_irq;
  assign busy      = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign ovf       = r_ovf;
  assign tout      = r_tout;

endmodule

// File: tb/tb_jtcontra_sndcmd.sv
// Bench for jtcontra_sndcmd: directed scenarios plus random traffic, every
// cycle compared against a queue-and-phase-timer model of the command flow.
module tb_jtcontra_sndcmd;

  localparam int IRQ_W = 8;
  localparam int TOUT  = 24000;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       cmd_we   = 1'b0;
  logic [7:0] cmd_din  = 8'h00;
  logic       snd_ack  = 1'b0;
  logic       flag_clr = 1'b0;
  logic       cmd_full;
  logic [7:0] snd_latch;
  logic       snd_irq;
  logic       busy;
  logic       ovf;
  logic       tout;

  always #5 clk = ~clk;

  jtcontra_sndcmd dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_we    (cmd_we),
    .cmd_din   (cmd_din),
    .cmd_full  (cmd_full),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .snd_ack   (snd_ack),
    .busy      (busy),
    .ovf       (ovf),
    .tout      (tout),
    .flag_clr  (flag_clr)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model: pending bytes, plus the age (m_d) of the command in flight,
  // counted in cycles since it was loaded.
  logic [7:0] m_q [$];
  bit         m_active;
  int         m_d;
  bit         m_ackp;
  logic [7:0] m_cur;
  logic [7:0] m_latch;
  bit         m_irq;
  bit         m_ovf;
  bit         m_tout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_d      = 0;
    m_ackp   = 0;
    m_cur    = 8'h00;
    m_latch  = 8'h00;
    m_irq    = 0;
    m_ovf    = 0;
    m_tout   = 0;
  endtask

  task automatic model_edge(input bit we, input logic [7:0] din, input bit ack, input bit clr);
    bit irq_now;
    irq_now = m_active && (m_d >= 1) && (m_d <= IRQ_W);
    if (!m_active) begin
      if (m_q.size() != 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1;
        m_d      = 0;
        m_ackp   = 0;
      end
    end else if (m_d == 0) begin
      m_latch = m_cur;
      m_d     = 1;
      $display("cmd %02h presented on snd_latch at t=%0t", m_cur, $time);
    end else if (m_d <= IRQ_W) begin
      if (ack) m_ackp = 1;
      if (m_d == IRQ_W && m_ackp) m_active = 0;
      else m_d++;
    end else begin
      if (ack) m_active = 0;
      else if (m_d - IRQ_W == TOUT) begin
        m_active = 0;
        m_tout   = 1;
      end else m_d++;
    end
    if (we) begin
      if (m_q.size() < DEPTH) m_q.push_back(din);
      else m_ovf = 1;
    end
    if (clr) begin
      m_ovf  = 0;
      m_tout = 0;
    end
    m_irq = irq_now;
  endtask

  task automatic check_all();
    check("latch", snd_latch, m_latch);
    check("irq",   snd_irq,   m_irq);
    check("full",  cmd_full,  m_q.size() == DEPTH);
    check("busy",  busy,      m_active || (m_q.size() != 0));
    check("ovf",   ovf,       m_ovf);
    check("tout",  tout,      m_tout);
  endtask

  task automatic cycle(input bit we = 0, input logic [7:0] din = 8'h00,
                       input bit ack = 0, input bit clr = 0);
    cmd_we   = we;
    cmd_din  = din;
    snd_ack  = ack;
    flag_clr = clr;
    @(posedge clk);
    model_edge(we, din, ack, clr);
    #1;
    check_all();
    cmd_we   = 0;
    snd_ack  = 0;
    flag_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit ack_on);
    int n = 0;
    while (busy && n < budget) begin
      cycle(.ack(ack_on));
      n++;
    end
    check("idle_bound", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq_hi;
    int gap;

    model_reset();
    do_reset();

    // Single command, no ack: full timeout
    cycle(1, 8'h5A);
    cycle();
    cycle();
    check("s1_latch", snd_latch, 8'h5A);
    irq_hi = 0;
    for (int i = 0; i < IRQ_W + 2; i++) begin
      cycle();
      if (snd_irq) irq_hi++;
    end
    check("s1_irq_len", irq_hi, IRQ_W);
    run_until_idle(TOUT + 50, 0);
    check("s1_tout", tout, 1'b1);
    cycle(.clr(1));
    check("s1_tout_clr", tout, 1'b0);

    // Overflow while waiting on 0x01
    cycle(1, 8'h01);
    repeat (IRQ_W + 2) cycle();
    for (int i = 0; i < 4; i++) cycle(1, 8'h10 + 8'(i));
    check("s2_full", cmd_full, 1'b1);
    check("s2_ovf0", ovf, 1'b0);
    cycle(1, 8'h14);
    check("s2_ovf1", ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(.ack(1));
      cycle();
      cycle();
      check("s2_order", snd_latch, 8'h10 + 8'(i));
      repeat (IRQ_W) cycle();
    end
    run_until_idle(10, 1);
    cycle(.clr(1));

    // Early ack in PULSE cycle 3
    cycle(1, 8'h21);
    cycle(1, 8'h22);
    cycle();
    check("s3_latch", snd_latch, 8'h21);
    cycle();
    cycle();
    cycle(.ack(1));
    gap = 3;
    while (snd_latch != 8'h22 && gap < 50) begin
      cycle();
      gap++;
    end
    check("s3_period", gap, IRQ_W + 2);
    run_until_idle(100, 1);

    // Push and pop in the same cycle while full, then flag clear vs drop
    cycle(1, 8'h30);
    repeat (IRQ_W + 2) cycle();
    for (int i = 0; i < 4; i++) cycle(1, 8'h31 + 8'(i));
    check("s4_full", cmd_full, 1'b1);
    cycle(.ack(1));
    cycle(1, 8'h77);
    check("s4_full_kept", cmd_full, 1'b1);
    check("s4_ovf", ovf, 1'b0);
    cycle(1, 8'h88, 0, 1);
    check("s6_clr_wins", ovf, 1'b0);
    cycle(1, 8'h99);
    check("s6_reset", ovf, 1'b1);
    cycle(.clr(1));
    run_until_idle(500, 1);
    check("s4_last", snd_latch, 8'h77);

    // Reset in PULSE cycle 4
    cycle(1, 8'h42);
    cycle(1, 8'h43);
    cycle();
    cycle();
    cycle();
    cycle();
    check("s5_irq_pre", snd_irq, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check("s5_irq",   snd_irq,   1'b0);
    check("s5_latch", snd_latch, 8'h00);
    check("s5_busy",  busy,      1'b0);
    check("s5_full",  cmd_full,  1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1, 8'hA5);
    cycle();
    cycle();
    check("s5_a5_latch", snd_latch, 8'hA5);
    cycle();
    check("s5_irq_first", snd_irq, 1'b1);
    repeat (IRQ_W - 1) cycle();
    check("s5_irq_last", snd_irq, 1'b1);
    cycle();
    check("s5_irq_end", snd_irq, 1'b0);
    run_until_idle(100, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle($urandom_range(0, 3) == 0, 8'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end
    run_until_idle(2000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
